// File: rtl/cam_sccb_sequencer.sv
// cam_sccb_sequencer: writes a register table to a camera over SCCB, then waits for the sensor to settle before enabling capture
// Ports:
//   p_clock, rst              clock and synchronous active-high reset
//   start                     one-cycle pulse that begins a run; only honoured in IDLE
//   rom_index / rom_data      table address out, {reg_addr, reg_value} back one cycle later
//   vsync                     camera frame sync, already in the p_clock domain
//   sioc / siod_out / siod_oe SCCB clock, data value and data enable (0 = released)
//   busy / cfg_done / capture_en  run status, sticky table-end flag, capture enable
module cam_sccb_sequencer #(
    parameter int         CLK_DIV       = 100,
    parameter logic [7:0] DEV_ID        = 8'h42,
    parameter int         SETTLE_FRAMES = 2,
    parameter int         IDX_W         = 6
) (
    input  logic             p_clock,
    input  logic             rst,
    input  logic             start,
    output logic [IDX_W-1:0] rom_index,
    input  logic [15:0]      rom_data,
    input  logic             vsync,
    output logic             sioc,
    output logic             siod_out,
    output logic             siod_oe,
    output logic             busy,
    output logic             cfg_done,
    output logic             capture_en
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int FW = $clog2(SETTLE_FRAMES + 2);

    typedef enum logic [2:0] {IDLE, FETCH, START, BIT, STOP, GAP, SETTLE, RUN} state_t;

    state_t        state;
    logic [DW-1:0] div;
    logic [1:0]    q;
    logic [4:0]    bit_cnt;
    logic [FW-1:0] frames;
    logic          fetch_wait;
    logic          vsync_q;
    logic [15:0]   entry;
    logic [26:0]   frame;
    logic          tick, phase_end, on_bus, x_bit;
    logic          nx_sioc, nx_siod, nx_oe;

    // X bits carry 1 so the line idles high when released for the slave's don't-care bit
    assign frame     = {DEV_ID, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
    assign tick      = div == DW'(CLK_DIV - 1);
    assign phase_end = tick && q == 2'd3;
    assign on_bus    = state inside {START, BIT, STOP, GAP};

    // Bus levels for the current quarter; registered below so every output is a flop
    always_comb begin
        x_bit   = bit_cnt == 5'd8 || bit_cnt == 5'd17 || bit_cnt == 5'd26;
        nx_sioc = state == BIT ? q[1] : state == STOP ? q != 2'd0 : 1'b1;
        nx_siod = state == START ? !q[1] :
                  state == BIT   ? frame[5'd26 - bit_cnt] :
                  state == STOP  ? q[1] : 1'b1;
        nx_oe   = !(state == BIT && x_bit);
    end

    always_ff @(posedge p_clock) begin
        if (rst) begin
            state      <= IDLE;
            div        <= '0;
            q          <= '0;
            bit_cnt    <= '0;
            frames     <= '0;
            fetch_wait <= 1'b0;
            entry      <= '0;
            vsync_q    <= 1'b0;
            rom_index  <= '0;
            sioc       <= 1'b1;
            siod_out   <= 1'b1;
            siod_oe    <= 1'b1;
            busy       <= 1'b0;
            cfg_done   <= 1'b0;
            capture_en <= 1'b0;
        end else begin
            vsync_q  <= vsync;
            sioc     <= nx_sioc;
            siod_out <= nx_siod;
            siod_oe  <= nx_oe;
            div      <= on_bus && !tick ? div + 1'b1 : '0;
            q        <= on_bus ? q + {1'b0, tick} : 2'd0;
            case (state)
                IDLE: if (start) begin
                    rom_index <= '0;
                    busy      <= 1'b1;
                    state     <= FETCH;
                end
                // First FETCH cycle presents the index; the second sees the matching table word
                FETCH: if (!fetch_wait) fetch_wait <= 1'b1;
                else begin
                    fetch_wait <= 1'b0;
                    entry      <= rom_data;
                    if (rom_data == 16'hFFFF) begin
                        cfg_done <= 1'b1;
                        if (SETTLE_FRAMES == 0) begin
                            capture_en <= 1'b1;
                            busy       <= 1'b0;
                            state      <= RUN;
                        end else state <= SETTLE;
                    end else state <= START;
                end
                START: if (phase_end) state <= BIT;
                BIT: if (phase_end) begin
                    bit_cnt <= bit_cnt == 5'd26 ? 5'd0 : bit_cnt + 1'b1;
                    if (bit_cnt == 5'd26) state <= STOP;
                end
                STOP: if (phase_end) state <= GAP;
                GAP: if (phase_end) begin
                    rom_index <= rom_index + 1'b1;
                    state     <= FETCH;
                end
                SETTLE: if (vsync && !vsync_q) begin
                    frames <= frames + 1'b1;
                    if (frames == FW'(SETTLE_FRAMES - 1)) begin
                        capture_en <= 1'b1;
                        busy       <= 1'b0;
                        state      <= RUN;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cam_sccb_sequencer.sv
// tb_cam_sccb_sequencer: randomized self-checking bench decoding the SCCB bus against the register table
module tb_cam_sccb_sequencer;
    localparam int CD = 2;
    localparam logic [26:0] OE_EXP = 27'h7FFFFFF & ~((27'd1 << 18) | (27'd1 << 9) | 27'd1);

    logic        p_clock = 1'b0, rst = 1'b1, start = 1'b0, start1 = 1'b0, vsync = 1'b0;
    logic [5:0]  rom_index, rom_index1;
    logic [15:0] rom_data = 16'hFFFF;
    logic        sioc, siod_out, siod_oe, busy, cfg_done, capture_en;
    logic        sioc1, siod_out1, siod_oe1, busy1, cfg_done1, capture_en1;
    logic [15:0] rom [64];
    int          vectors = 0, errors = 0, cyc = 0;

    cam_sccb_sequencer #(.CLK_DIV(CD), .DEV_ID(8'h42), .SETTLE_FRAMES(2), .IDX_W(6)) dut (
        .p_clock(p_clock), .rst(rst), .start(start), .rom_index(rom_index), .rom_data(rom_data),
        .vsync(vsync), .sioc(sioc), .siod_out(siod_out), .siod_oe(siod_oe), .busy(busy),
        .cfg_done(cfg_done), .capture_en(capture_en));

    cam_sccb_sequencer #(.CLK_DIV(CD), .DEV_ID(8'h42), .SETTLE_FRAMES(0), .IDX_W(6)) dut0 (
        .p_clock(p_clock), .rst(rst), .start(start1), .rom_index(rom_index1), .rom_data(16'hFFFF),
        .vsync(vsync), .sioc(sioc1), .siod_out(siod_out1), .siod_oe(siod_oe1), .busy(busy1),
        .cfg_done(cfg_done1), .capture_en(capture_en1));

    always #5 p_clock = ~p_clock;

    always @(posedge p_clock) begin
        cyc      <= cyc + 1;
        rom_data <= rom[rom_index];
    end

    // Bus decoder: start/stop conditions, data sampled on sioc rising, pulled-up line when released
    logic        ps_c = 1'b1, ps_d = 1'b1, mon_in = 1'b0, d;
    int          mon_nb = 0, t0 = 0, oelow = 0, act1 = 0;
    logic [26:0] bits, oeb;
    logic [26:0] q_bits[$], q_oe[$];
    int          q_nb[$], q_t0[$], q_t1[$], q_oelow[$];

    always @(negedge p_clock) begin
        d = siod_oe ? siod_out : 1'b1;
        if (rst) mon_in = 1'b0;
        else if (ps_c && sioc && ps_d && !d) begin
            mon_in = 1'b1; mon_nb = 0; bits = '0; oeb = '0; oelow = 0; t0 = cyc;
        end else if (mon_in && ps_c && sioc && !ps_d && d) begin
            q_bits.push_back(bits); q_oe.push_back(oeb); q_nb.push_back(mon_nb);
            q_t0.push_back(t0); q_t1.push_back(cyc); q_oelow.push_back(oelow);
            mon_in = 1'b0;
        end else if (mon_in && !ps_c && sioc && mon_nb < 27) begin
            bits = {bits[25:0], d}; oeb = {oeb[25:0], siod_oe}; mon_nb++;
        end
        if (mon_in && !siod_oe) oelow++;
        if (rst) act1 = 0;
        else if (!sioc1 || !siod_out1 || !siod_oe1) act1++;
        ps_c = sioc; ps_d = d;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge p_clock);
        #1;
    endtask

    task automatic fill();
        foreach (rom[i]) rom[i] = 16'hFFFF;
    endtask

    task automatic do_reset();
        rst = 1'b1; vsync = 1'b0; step(2);
        q_bits.delete(); q_oe.delete(); q_nb.delete(); q_t0.delete(); q_t1.delete(); q_oelow.delete();
        rst = 1'b0; step(1);
    endtask

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    // vsync toggles randomly while a transaction is on the bus; those edges must never count
    task automatic wait_done(input string name);
        int n = 0;
        while (!cfg_done && n < 20000) begin
            step(1);
            vsync = mon_in ? 1'($urandom_range(0, 1)) : 1'b0;
            n++;
        end
        vsync = 1'b0;
        vectors++;
        if (cfg_done !== 1'b1) begin errors++; $display("FAIL %s_timeout cfg_done=%b required 1", name, cfg_done); end
    endtask

    task automatic wait_bits(input int nb);
        int n = 0;
        while (!(mon_in && mon_nb >= nb) && n < 5000) begin step(1); n++; end
        vectors++;
        if (!(mon_in && mon_nb >= nb)) begin errors++; $display("FAIL wait_bits got %0d bits required %0d", mon_nb, nb); end
    endtask

    task automatic check_frame(input string name, input logic [15:0] e);
        logic [26:0] b, o;
        int nb, dur, ol;
        vectors++;
        if (q_bits.size() == 0) begin
            errors++; $display("FAIL %s_missing no transaction seen required entry %h", name, e);
            return;
        end
        b = q_bits.pop_front(); o = q_oe.pop_front(); nb = q_nb.pop_front();
        dur = q_t1.pop_front() - q_t0.pop_front(); ol = q_oelow.pop_front();
        if (nb != 27 || {b[26:19], b[17:10], b[8:1]} !== {8'h42, e}) begin
            errors++; $display("FAIL %s_bytes got %0d bits %h required 27 bits 42%h", name, nb, {b[26:19], b[17:10], b[8:1]}, e);
        end
        vectors++;
        if (o !== OE_EXP) begin errors++; $display("FAIL %s_oe got %b required %b", name, o, OE_EXP); end
        // start-fall to stop-rise spans 112 of the 116 quarters; START q0-1 and STOP q2-3 lie outside
        vectors++;
        if (dur != 112 * CD) begin errors++; $display("FAIL %s_duration got %0d required %0d", name, dur, 112 * CD); end
        vectors++;
        if (ol != 3 * 4 * CD) begin errors++; $display("FAIL %s_x_release got %0d required %0d", name, ol, 12 * CD); end
    endtask

    task automatic check_settle(input string name);
        logic cb, ca, bb, ba;
        vsync = 1'b1; step(1); ca = capture_en; step(2); vsync = 1'b0; step(4);
        vectors++;
        if (ca !== 1'b0) begin errors++; $display("FAIL %s_first_edge capture_en=%b required 0", name, ca); end
        vsync = 1'b1; cb = capture_en; bb = busy; step(1); ca = capture_en; ba = busy; step(2); vsync = 1'b0; step(4);
        vectors++;
        if ({cb, ca, bb, ba} !== 4'b0110) begin
            errors++; $display("FAIL %s_second_edge capture_en %b->%b busy %b->%b required 0->1 1->0", name, cb, ca, bb, ba);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; step(1);
        vectors++;
        if ({sioc, siod_out, siod_oe, busy, cfg_done, capture_en} !== 6'b111000) begin
            errors++; $display("FAIL reset_outputs got %b required 111000", {sioc, siod_out, siod_oe, busy, cfg_done, capture_en});
        end
        vectors++;
        if (rom_index !== 6'd0) begin errors++; $display("FAIL reset_index got %0d required 0", rom_index); end
        vectors++;
        if ({busy1, cfg_done1, capture_en1} !== 3'b000) begin
            errors++; $display("FAIL reset_second got %b required 000", {busy1, cfg_done1, capture_en1});
        end
    endtask

    task automatic test_single();
        fill(); rom[0] = 16'h1280; do_reset(); pulse_start(); wait_done("single"); step(2);
        vectors++;
        if (q_bits.size() != 1) begin errors++; $display("FAIL single_count got %0d required 1", q_bits.size()); end
        check_frame("single", 16'h1280);
        vectors++;
        if ({cfg_done, busy, capture_en} !== 3'b110) begin
            errors++; $display("FAIL single_status got %b required 110", {cfg_done, busy, capture_en});
        end
        check_settle("single");
        vsync = 1'b1; step(3); vsync = 1'b0; step(3);
        pulse_start(); step(40);
        vectors++;
        if ({capture_en, busy, cfg_done, rom_index} !== {3'b101, 6'd1} || q_bits.size() != 0) begin
            errors++; $display("FAIL run_ignore got cap/busy/done/idx %b%b%b/%0d frames %0d required 101/1 0",
                capture_en, busy, cfg_done, rom_index, q_bits.size());
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        fill(); rom[0] = 16'h1204; rom[1] = 16'h40D0; do_reset(); pulse_start();
        wait_bits(5); pulse_start();
        wait_done("b2b"); step(2);
        vectors++;
        if (q_bits.size() != 2) begin errors++; $display("FAIL b2b_count got %0d required 2", q_bits.size()); end
        // stop-rise to next start-fall: STOP q2-3, GAP, 2 FETCH cycles, START q0-1
        gap = q_t0.size() >= 2 ? q_t0[1] - q_t1[0] : -1;
        vectors++;
        if (gap != 8 * CD + 2) begin errors++; $display("FAIL b2b_gap got %0d required %0d", gap, 8 * CD + 2); end
        check_frame("b2b0", 16'h1204);
        check_frame("b2b1", 16'h40D0);
        vectors++;
        if (rom_index !== 6'd2) begin errors++; $display("FAIL b2b_index got %0d required 2", rom_index); end
    endtask

    task automatic test_random();
        logic [15:0] exp_q[$];
        for (int it = 0; it < 3; it++) begin
            int n;
            logic [15:0] e;
            n = $urandom_range(1, 3);
            fill(); exp_q.delete();
            for (int i = 0; i < n; i++) begin
                e = 16'($urandom);
                if (e == 16'hFFFF) e = 16'h5A5A;
                rom[i] = e; exp_q.push_back(e);
            end
            do_reset(); pulse_start(); wait_done("random"); step(2);
            vectors++;
            if (q_bits.size() != n) begin errors++; $display("FAIL random_count got %0d required %0d", q_bits.size(), n); end
            foreach (exp_q[i]) check_frame("random", exp_q[i]);
            vectors++;
            if (rom_index !== 6'(n)) begin errors++; $display("FAIL random_index got %0d required %0d", rom_index, n); end
            check_settle("random");
        end
    endtask

    task automatic test_reset_abort();
        fill(); rom[0] = 16'h1280; rom[1] = 16'h3355; do_reset(); pulse_start();
        wait_bits(22);
        rst = 1'b1; step(1);
        vectors++;
        if ({sioc, siod_out, busy} !== 3'b110) begin
            errors++; $display("FAIL abort_outputs got sioc/siod/busy %b required 110", {sioc, siod_out, busy});
        end
        rst = 1'b0; step(20);
        vectors++;
        if (q_bits.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_quiet got frames %0d busy %b required 0 0", q_bits.size(), busy);
        end
        pulse_start(); wait_done("abort"); step(2);
        vectors++;
        if (q_bits.size() != 2) begin errors++; $display("FAIL abort_count got %0d required 2", q_bits.size()); end
        check_frame("abort0", 16'h1280);
        check_frame("abort1", 16'h3355);
    endtask

    task automatic test_no_settle();
        int t = 1;
        do_reset();
        start1 = 1'b1; step(1); start1 = 1'b0;
        while (!capture_en1 && t < 3) begin step(1); t++; end
        vectors++;
        if ({capture_en1, cfg_done1, busy1} !== 3'b110 || act1 != 0) begin
            errors++; $display("FAIL no_settle got cap/done/busy %b activity %0d after %0d cycles required 110 0",
                {capture_en1, cfg_done1, busy1}, act1, t);
        end
    endtask

    initial begin
        fill();
        test_reset();
        test_single();
        test_reset();
        test_back_to_back();
        test_random();
        test_reset_abort();
        test_no_settle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/cam_sccb_sequencer.md
CAM_SCCB_SEQUENCER -- requirements
Module: cam_sccb_sequencer

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 100, giving p_clock cycles per SCCB quarter-bit.
REQ-002 The block SHALL have parameter DEV_ID, default 8'h42, giving the 8-bit SCCB write ID.
REQ-003 The block SHALL have parameter SETTLE_FRAMES, default 2, giving the vsync rising edges to wait after configuration.
REQ-004 The block SHALL have parameter IDX_W, default 6, giving the width of the table index.
REQ-005 p_clock  in  1  system/pixel clock; all logic is on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle pulse that begins a configuration run.
REQ-008 rom_index  out  IDX_W  table entry address.
REQ-009 rom_data  in  16  table entry, {reg_addr[15:8], reg_value[7:0]}, valid the cycle after rom_index changes.
REQ-010 vsync  in  1  camera frame sync, already synchronous to p_clock.
REQ-011 sioc  out  1  SCCB clock.
REQ-012 siod_out  out  1  SCCB data value.
REQ-013 siod_oe  out  1  SCCB data drive enable; 0 = released.
REQ-014 busy  out  1  high from accepted start until capture_en asserts.
REQ-015 cfg_done  out  1  sticky high once the table end is reached.
REQ-016 capture_en  out  1  enable for the capture datapath.

Function
REQ-017 The block SHALL implement states IDLE, FETCH, START, BIT, STOP, GAP, SETTLE and RUN.
REQ-018 In IDLE, a start pulse SHALL clear rom_index to 0 and enter FETCH; start in any other state SHALL be ignored.
REQ-019 FETCH SHALL latch rom_data one cycle after rom_index is presented.
REQ-020 If the latched entry is 16'hFFFF, FETCH SHALL set cfg_done and enter SETTLE; otherwise it SHALL enter START.
REQ-021 Every SCCB phase SHALL be 4 quarters of CLK_DIV cycles each.
REQ-022 START SHALL hold sioc=1 throughout, with siod_out=1 in quarters 0-1 and siod_out=0 in quarters 2-3.
REQ-023 BIT SHALL shift 27 bits MSB-first: DEV_ID, X, reg_addr, X, reg_value, X.
REQ-024 Each bit SHALL use sioc=0 in quarters 0-1 and sioc=1 in quarters 2-3, with siod_out updated only at the start of quarter 0.
REQ-025 During each X (9th) bit, siod_oe SHALL be 0; siod_oe SHALL be 1 during all other bits.
REQ-026 STOP SHALL drive siod_out=0 in quarter 0, sioc=1 from quarter 1, and siod_out=1 from quarter 2.
REQ-027 GAP SHALL idle the bus (sioc=1, siod_out=1, siod_oe=1) for 4*CLK_DIV cycles, then increment rom_index and enter FETCH.
REQ-028 One register write, START through STOP, SHALL take exactly 116*CLK_DIV cycles.
REQ-029 rom_index SHALL wrap from 2^IDX_W-1 to 0 without a sentinel; the sequence SHALL continue, and the table owner guarantees a sentinel.
REQ-030 SETTLE SHALL count vsync rising edges, detected against a one-cycle registered copy of vsync.
REQ-031 On reaching SETTLE_FRAMES edges, SETTLE SHALL assert capture_en, clear busy and enter RUN on the following cycle.
REQ-032 With SETTLE_FRAMES=0, the block SHALL enter RUN directly from FETCH.
REQ-033 RUN SHALL be terminal: capture_en SHALL stay 1 and start SHALL be ignored until rst.
REQ-034 A vsync edge arriving in a cycle other than SETTLE SHALL NOT be counted.

Reset
REQ-035 When rst is high at a clock edge, the block SHALL enter IDLE and set sioc=1, siod_out=1, siod_oe=1, busy=0, cfg_done=0, capture_en=0, rom_index=0, and clear all counters.
REQ-036 rst mid-transaction SHALL abort immediately, producing no stop condition; the next start SHALL restart from entry 0.
REQ-037 rst SHALL take priority over start in the same cycle.

Verification
REQ-038 With CLK_DIV=2, table {16'h1280, 16'hFFFF} and a start pulse, the bench SHALL see one transaction shifting 0x42, 0x12, 0x80, with siod_oe=0 for 8 cycles per X bit, the transaction lasting 232 cycles, and cfg_done=1 afterward.
REQ-039 With table {16'h1204, 16'h40D0, 16'hFFFF}, the bench SHALL see two transactions separated by an 8-cycle GAP, and rom_index SHALL reach 2.
REQ-040 With SETTLE_FRAMES=2 and 3 vsync pulses after cfg_done, the bench SHALL see capture_en rise 1 cycle after the 2nd rising edge and busy fall in the same cycle.
REQ-041 With rst asserted mid-way through reg_value bit 4, the next cycle SHALL show sioc=1, siod_out=1, busy=0, and a new start SHALL produce a fresh transaction from entry 0.
REQ-042 A start pulse during BIT and during RUN SHALL leave state and outputs unaffected.
REQ-043 With table {16'hFFFF} and SETTLE_FRAMES=0, start SHALL produce no SCCB activity, set cfg_done=1, and assert capture_en within 3 cycles.
